// File: rtl/tms9918_video_timing.sv
// TMS9918 native-rate raster generator: 342-pixel lines, NTSC/PAL frame
// heights, sync/burst gates, backdrop substitution and a one-tick pixel fetch.
module tms9918_video_timing #(
  parameter int V_BOTTOM_BORDER = 24,
  parameter int V_TOP_BORDER    = 27
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic       blank,
  input  logic [0:3] backdrop,
  input  logic [0:3] pixel_color,
  output logic       pixel_req,
  output logic [0:7] pixel_x,
  output logic [0:7] pixel_y,
  output logic       sync_h,
  output logic       cburst,
  output logic       sync_v,
  output logic [0:3] color,
  output logic       frame_start
);

  localparam int V_TOTAL      = 192 + V_BOTTOM_BORDER + 3 + 3 + 13 + V_TOP_BORDER;
  localparam int VW           = (V_TOTAL > 256) ? $clog2(V_TOTAL) : 8;
  localparam int V_BOT_END    = 192 + V_BOTTOM_BORDER;
  localparam int V_SYNC_START = V_BOT_END + 3;
  localparam int V_SYNC_END   = V_SYNC_START + 3;
  localparam int V_TOP_START  = V_SYNC_END + 13;

  localparam logic [8:0]    H_LAST = 9'd341;
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [8:0]    h;
  logic [VW-1:0] v;

  logic h_sync, h_burst, h_act, h_bord, h_req;
  logic v_act, v_bord, v_sync;
  logic [0:3] color_nxt;

  // Horizontal decode
  always_comb begin
    h_sync  = (h <= 9'd25);
    h_burst = (h >= 9'd28) && (h <= 9'd41);
    h_act   = (h >= 9'd63) && (h <= 9'd318);
    h_bord  = ((h >= 9'd50) && (h <= 9'd62)) || ((h >= 9'd319) && (h <= 9'd333));
    h_req   = (h >= 9'd62) && (h <= 9'd317);
  end

  // Vertical decode; the border bands shrink to nothing if a border parameter is 0
  always_comb begin
    v_act  = (v <= VW'(191));
    v_bord = ((v >= VW'(192)) && (v < VW'(V_BOT_END))) || (v >= VW'(V_TOP_START));
    v_sync = (v >= VW'(V_SYNC_START)) && (v < VW'(V_SYNC_END));
  end

  // A border-v line crossing active-h is border, so active needs both axes
  always_comb begin
    color_nxt = 4'h0;
    if (h_act && v_act)
      color_nxt = blank ? backdrop : pixel_color;
    else if ((h_act || h_bord) && (v_act || v_bord))
      color_nxt = backdrop;
  end

  // Fetch runs one tick ahead of display: request at h, colour consumed at h+1
  assign pixel_req = clk_en && v_act && h_req;
  assign pixel_x   = 8'(h - 9'd62);
  assign pixel_y   = v[7:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h           <= '0;
      v           <= '0;
      sync_h      <= 1'b0;
      cburst      <= 1'b0;
      sync_v      <= 1'b0;
      color       <= 4'h0;
      frame_start <= 1'b0;
    end else if (clk_en) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      sync_h      <= h_sync;
      cburst      <= h_burst && !v_sync;
      sync_v      <= v_sync;
      color       <= color_nxt;
      frame_start <= (h == '0) && (v == '0);
    end
  end

endmodule

// File: tb/tb_tms9918_video_timing.sv
// Directed bench for tms9918_video_timing: line timing, fetch handshake,
// blanking, full NTSC frame, PAL vsync placement and reset under sparse clk_en.
module tb_tms9918_video_timing;

  logic       clk = 1'b0;
  logic       reset_n, clk_en, blank;
  logic [0:3] backdrop, pixel_color;
  logic       pixel_req, sync_h, cburst, sync_v, frame_start;
  logic [0:7] pixel_x, pixel_y;
  logic [0:3] color;

  logic       p_req, p_sync_h, p_cburst, p_sync_v, p_frame_start;
  logic [0:7] p_x, p_y;
  logic [0:3] p_color;

  int tests = 0;
  int fails = 0;
  int hh = 0;
  int vv = 0;

  always #5 clk = ~clk;

  tms9918_video_timing dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .blank(blank),
    .backdrop(backdrop), .pixel_color(pixel_color), .pixel_req(pixel_req),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .sync_h(sync_h), .cburst(cburst),
    .sync_v(sync_v), .color(color), .frame_start(frame_start)
  );

  tms9918_video_timing #(.V_BOTTOM_BORDER(51), .V_TOP_BORDER(51)) dut_pal (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .blank(blank),
    .backdrop(backdrop), .pixel_color(pixel_color), .pixel_req(p_req),
    .pixel_x(p_x), .pixel_y(p_y), .sync_h(p_sync_h), .cburst(p_cburst),
    .sync_v(p_sync_v), .color(p_color), .frame_start(p_frame_start)
  );

  // One enabled tick; bench position follows the NTSC raster
  task automatic step();
    @(posedge clk); #1;
    hh++;
    if (hh == 342) begin
      hh = 0;
      vv++;
      if (vv == 262) vv = 0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clk_en = 1'b0; blank = 1'b0;
    backdrop = 4'h5; pixel_color = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({sync_h, cburst, sync_v, frame_start, color} !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs got %b required 00000000", {sync_h, cburst, sync_v, frame_start, color});
    end
    tests++;
    if (pixel_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_req got %b required 0", pixel_req);
    end
    reset_n = 1'b1;
    hh = 0; vv = 0;
  endtask

  task automatic test_line0();
    logic [0:3] pending, exp_col;
    logic       exp_req;
    int         req_cnt, ph;
    pending = 4'hF; req_cnt = 0;
    clk_en = 1'b1; blank = 1'b0; backdrop = 4'h5;
    for (int i = 0; i < 342; i++) begin
      exp_req = (i >= 62) && (i <= 317);
      tests++;
      if (pixel_req !== exp_req) begin
        fails++;
        $display("FAIL line0_req h=%0d got %b required %b", i, pixel_req, exp_req);
      end
      if (exp_req) begin
        tests++;
        if (pixel_x !== 8'(i - 62) || pixel_y !== 8'd0) begin
          fails++;
          $display("FAIL line0_xy h=%0d got %0d,%0d required %0d,0", i, pixel_x, pixel_y, i - 62);
        end
      end
      pixel_color = pending;
      if (pixel_req) begin
        pending = pixel_x[4:7];
        req_cnt++;
      end
      ph = hh;
      step();
      if (ph >= 63 && ph <= 318) exp_col = 4'((ph - 63) & 15);
      else if ((ph >= 50 && ph <= 62) || (ph >= 319 && ph <= 333)) exp_col = 4'h5;
      else exp_col = 4'h0;
      tests++;
      if (color !== exp_col) begin
        fails++;
        $display("FAIL line0_color h=%0d got %h required %h", ph, color, exp_col);
      end
      tests++;
      if (sync_h !== (ph <= 25) || cburst !== (ph >= 28 && ph <= 41) ||
          frame_start !== (ph == 0) || sync_v !== 1'b0) begin
        fails++;
        $display("FAIL line0_sync h=%0d got hs=%b cb=%b fs=%b vs=%b", ph, sync_h, cburst, frame_start, sync_v);
      end
      if (ph == 0) begin
        tests++;
        if (p_frame_start !== 1'b1 || p_sync_h !== 1'b1) begin
          fails++;
          $display("FAIL pal_first_tick got fs=%b hs=%b required 1 1", p_frame_start, p_sync_h);
        end
      end
    end
    tests++;
    if (req_cnt != 256) begin
      fails++;
      $display("FAIL line0_req_count got %0d required 256", req_cnt);
    end
  endtask

  task automatic test_blank_line();
    logic [0:3] exp_col;
    logic       exp_req;
    int         ph, req_cnt;
    req_cnt = 0;
    pixel_color = 4'h9;
    while (vv < 10) step();
    blank = 1'b1; backdrop = 4'hA; pixel_color = 4'h3;
    for (int i = 0; i < 342; i++) begin
      exp_req = (hh >= 62) && (hh <= 317);
      tests++;
      if (pixel_req !== exp_req || (exp_req && pixel_y !== 8'd10)) begin
        fails++;
        $display("FAIL blank_req h=%0d got req=%b y=%0d required %b,10", hh, pixel_req, pixel_y, exp_req);
      end
      if (pixel_req) req_cnt++;
      ph = hh;
      step();
      exp_col = (ph >= 50 && ph <= 333) ? 4'hA : 4'h0;
      tests++;
      if (color !== exp_col) begin
        fails++;
        $display("FAIL blank_color h=%0d got %h required %h", ph, color, exp_col);
      end
    end
    tests++;
    if (req_cnt != 256) begin
      fails++;
      $display("FAIL blank_req_count got %0d required 256", req_cnt);
    end
    blank = 1'b0; backdrop = 4'h5; pixel_color = 4'h9;
  endtask

  task automatic test_frame();
    logic [0:3] exp_col;
    logic       exp_req, exp_vs, exp_cb;
    int         ph, pv;
    while (vv != 0) begin
      exp_req = (vv <= 191) && (hh >= 62) && (hh <= 317);
      tests++;
      if (pixel_req !== exp_req) begin
        fails++;
        $display("FAIL frame_req v=%0d h=%0d got %b required %b", vv, hh, pixel_req, exp_req);
      end
      ph = hh; pv = vv;
      step();
      exp_vs = (pv >= 219) && (pv <= 221);
      exp_cb = (ph >= 28) && (ph <= 41) && !exp_vs;
      tests++;
      if (sync_v !== exp_vs || cburst !== exp_cb || frame_start !== 1'b0) begin
        fails++;
        $display("FAIL frame_sync v=%0d h=%0d got vs=%b cb=%b fs=%b required %b %b 0",
                 pv, ph, sync_v, cburst, frame_start, exp_vs, exp_cb);
      end
      tests++;
      if (p_sync_v !== ((pv >= 246) && (pv <= 248))) begin
        fails++;
        $display("FAIL pal_sync_v v=%0d h=%0d got %b", pv, ph, p_sync_v);
      end
      if (pv >= 192) begin
        exp_col = ((pv <= 215 || pv >= 235) && ph >= 50 && ph <= 333) ? 4'h5 : 4'h0;
        tests++;
        if (color !== exp_col) begin
          fails++;
          $display("FAIL vborder_color v=%0d h=%0d got %h required %h", pv, ph, color, exp_col);
        end
      end
    end
    // NTSC wraps to line 0 here; PAL is only at line 262
    step();
    tests++;
    if (frame_start !== 1'b1 || p_frame_start !== 1'b0) begin
      fails++;
      $display("FAIL frame_wrap got fs=%b pal_fs=%b required 1 0", frame_start, p_frame_start);
    end
  endtask

  task automatic test_quarter_duty();
    reset_n = 1'b0; clk_en = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; hh = 0; vv = 0;
    pixel_color = 4'h7; backdrop = 4'h5; blank = 1'b0;
    for (int t = 0; t < 100; t++) begin
      clk_en = 1'b1;
      step();
      clk_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        if (t == 30) begin
          tests++;
          if (sync_h !== 1'b0 || cburst !== 1'b1) begin
            fails++;
            $display("FAIL hold_burst idle=%0d got hs=%b cb=%b required 0 1", k, sync_h, cburst);
          end
        end
        if (t == 70) begin
          tests++;
          if (color !== 4'h7 || pixel_req !== 1'b0) begin
            fails++;
            $display("FAIL hold_active idle=%0d got col=%h req=%b required 7 0", k, color, pixel_req);
          end
        end
      end
    end
    tests++;
    if (color !== 4'h7) begin
      fails++;
      $display("FAIL pre_reset_color got %h required 7", color);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({sync_h, cburst, sync_v, frame_start, color} !== 8'h00) begin
      fails++;
      $display("FAIL midline_reset got %b required 00000000", {sync_h, cburst, sync_v, frame_start, color});
    end
    #2 reset_n = 1'b1;
    hh = 0; vv = 0;
    @(posedge clk); #1;
    clk_en = 1'b1;
    step();
    clk_en = 1'b0;
    tests++;
    if (sync_h !== 1'b1 || frame_start !== 1'b1 || color !== 4'h0) begin
      fails++;
      $display("FAIL restart_tick got hs=%b fs=%b col=%h required 1 1 0", sync_h, frame_start, color);
    end
  endtask

  initial begin
    test_reset();
    test_line0();
    test_blank_line();
    test_frame();
    test_quarter_duty();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tms9918_video_timing.md
Name: tms9918_video_timing

Overview:
- Generates the native-rate TMS9918 raster: horizontal/vertical counters, sync_h, cburst, sync_v and the 4-bit colour stream.
- This is the same pixel-stream interface that the scan doubler consumes (color, sync_h, cburst, one pixel per clk_en); this block produces it.
- Requests active-area pixels from the pattern/sprite pipeline with a one-tick fetch handshake.
- Substitutes the backdrop colour in the border and 0 in blanking.

Parameters:
V_BOTTOM_BORDER, 24, bottom border lines (24 NTSC; 51 for PAL).
V_TOP_BORDER, 27, top border lines (27 NTSC; 51 for PAL).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clk_en  in  1  pixel-clock enable; one raster pixel per asserted cycle
blank  in  1  display-disable bit; when 1, the active area shows backdrop
backdrop  in  [0:3]  border/backdrop colour
pixel_color  in  [0:3]  pixel from the pipeline, valid at the tick after pixel_req
pixel_req  out  1  fetch strobe (combinational, qualified by clk_en)
pixel_x  out  [0:7]  x of the requested pixel
pixel_y  out  [0:7]  y of the requested pixel
sync_h  out  1  horizontal sync, active high
cburst  out  1  colour-burst gate
sync_v  out  1  vertical sync, active high
color  out  [0:3]  output pixel colour
frame_start  out  1  one-tick pulse at the start of line 0

Behaviour:
- Counters h (0..341) and v (0..V_TOTAL-1) advance only on clk_en.
- V_TOTAL = 192 + V_BOTTOM_BORDER + 3 + 3 + 13 + V_TOP_BORDER; defaults give 262.
- h wraps 341 to 0 and increments v; v wraps V_TOTAL-1 to 0.
- Horizontal map by h:
  0-25 hsync; 26-27 blank; 28-41 burst; 42-49 blank; 50-62 left border; 63-318 active; 319-333 right border; 334-341 blank.
- Vertical map by v:
  0-191 active; then bottom border; 3 blank lines; 3 vsync lines; 13 blank lines; top border.
- On each clk_en, outputs register from the pre-advance (h,v):
  - sync_h = (h<=25).
  - cburst = (28<=h<=41), but 0 on vsync lines.
  - sync_v = v in the vsync band.
  - frame_start = (h==0 && v==0).
  - color:
    - active h and active v: pixel_color when blank=0, else backdrop;
    - border h or border v, not blank: backdrop;
    - otherwise 0.
  - A pixel that is both border-v and active-h is border.
- Outputs hold between enables. Latency is one clock after the clk_en edge.
- Fetch:
  - pixel_req = clk_en && v<=191 && 62<=h<=317.
  - pixel_x = h-62 (8 bits, 0..255); pixel_y = v[7:0].
  - pixel_x/pixel_y are driven continuously from the counters; they are don't-care when pixel_req=0.
  - The pipeline must present pixel_color before the next clk_en, at which h = 63..318; the block samples it then.
  - pixel_req is issued even when blank=1; the result is ignored.
- Reset (async, reset_n=0):
  - h=0, v=0;
  - sync_h=0, cburst=0, sync_v=0, color=0, frame_start=0.
  - The first clk_en after release registers h=0,v=0: sync_h=1, frame_start=1.
- Reset mid-line aborts the line immediately. No partial-line state survives.
- clk_en held low: counters and outputs frozen indefinitely, pixel_req=0.
- backdrop and blank are sampled per tick, so mid-line changes take effect at the next tick.

Test Plan:
- Reset, then clk_en every cycle for 342 ticks -> sync_h high for exactly 26 ticks from the first tick; cburst high for ticks 28-41; color=backdrop for ticks 50-62 and 319-333; color=0 for 26-49 and 334-341.
- Line 0, pixel_color driven as pixel_x[4:7] -> pixel_req pulses 256 times (h=62..317, pixel_x 0..255); color on h=63..318 equals the x low nibble, one tick after each request.
- Full frame with defaults -> frame_start once per 262*342 ticks; sync_v high on lines 219-221; cburst=0 on those lines; pixel_req never asserted on lines 192-261.
- blank=1, backdrop=4'hA, line 10 -> color=A across h=50..333 and 0 in blanking; pixel_req still pulses.
- V_BOTTOM_BORDER=51, V_TOP_BORDER=51 -> frame of 313 lines; sync_v on lines 246-248.
- clk_en at 1/4 duty with reset_n pulsed low mid-line 100 -> outputs 0 immediately; the next clk_en shows sync_h=1, frame_start=1.
